axi_rd_sched: RTL and testbench

- Schedules the single shared AXI read channel (AR/R) between NUM_M cache-side read requesters, e.g. d_cache refill/uncached read at index 0 and i_cache refill at index 1.
- Sits between the caches and the external AXI port, beside the write-channel logic.
- Allows one outstanding read burst at a time, tags it with the winner's index on arid, and steers R beats back to the winner only.
- Checks R-channel protocol: rid match and rlast position.

---
 rtl/axi_rd_sched_if.sv | 52 +++++
 rtl/axi_rd_sched.sv | 185 ++++++++++++++++++
 tb/tb_axi_rd_sched.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_sched_if.sv
// Bundles the requester-side and AXI-side read-channel signals of axi_rd_sched.
// master = scheduler view; slave = view of the environment (requesters plus AXI slave).
interface axi_rd_sched_if #(
    parameter int NUM_M = 2
);
    // Handshakes: a transfer occurs on a rising clock edge where valid and ready are both 1;
    // the source holds its payload stable while valid is high, and ready may depend on valid.
    logic [NUM_M*32-1:0] m_araddr;
    logic [NUM_M*4-1:0]  m_arlen;
    logic [NUM_M-1:0]    m_arvalid;
    logic [NUM_M-1:0]    m_arready;
    logic [31:0]         m_rdata;
    logic [1:0]          m_rresp;
    logic [NUM_M-1:0]    m_rlast;
    logic [NUM_M-1:0]    m_rvalid;
    logic [NUM_M-1:0]    m_rready;

    logic [3:0]          arid;
    logic [31:0]         araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [3:0]          rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        input  m_araddr, m_arlen, m_arvalid, m_rready,
        output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output m_araddr, m_arlen, m_arvalid, m_rready,
        input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_rd_sched.sv
// Single-outstanding AXI read scheduler for NUM_M cache requesters, with R-channel checking.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (index 0 first).
module axi_rd_sched #(
    parameter int NUM_M   = 2,
    parameter int ID_BASE = 0
) (
    input  logic          aclk,
    input  logic          aresetn,
    axi_rd_sched_if.master bus,
    output logic          busy,
    output logic [1:0]    grant_id,
    output logic          proto_err,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_arvalid;
    logic [3:0]        r_arid;
    logic [31:0]       r_araddr;
    logic [3:0]        r_arlen;
    logic [1:0]        r_grant;
    logic [3:0]        r_beat_cnt;
    logic              r_proto_err;

    logic              w_any;
    logic [1:0]        w_winner;
    logic [31:0]       w_addr;
    logic [3:0]        w_len;
    logic [3:0]        w_arid;
    logic [NUM_M-1:0]  w_gnt_oh;
    logic              w_beat;
    logic              w_err;

`ifdef ARB_RR_EN
    logic [1:0]        r_ptr;

    // Scan from the pointer upward; descending k lets the nearest requester win.
    always_comb begin
        w_winner = 2'd0;
        for (int p = 0; p < NUM_M; p++) begin
            if (r_ptr == 2'(p)) begin
                for (int k = NUM_M - 1; k >= 0; k--) begin
                    if (bus.m_arvalid[(p + k) % NUM_M]) begin
                        w_winner = 2'((p + k) % NUM_M);
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_ptr <= 2'd0;
        end else if (r_state == S_IDLE && w_any) begin
            r_ptr <= (w_winner == 2'(NUM_M - 1)) ? 2'd0 : w_winner + 2'd1;
        end
    end
`else
    always_comb begin
        w_winner = 2'd0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (bus.m_arvalid[i]) begin
                w_winner = 2'(i);
            end
        end
    end
`endif

    assign w_any  = |bus.m_arvalid;
    assign w_arid = 4'(ID_BASE) + {2'b00, w_winner};

    always_comb begin
        w_addr = 32'd0;
        w_len  = 4'd0;
        for (int i = 0; i < NUM_M; i++) begin
            if (w_winner == 2'(i)) begin
                w_addr = bus.m_araddr[32*i +: 32];
                w_len  = bus.m_arlen[4*i +: 4];
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        for (int i = 0; i < NUM_M; i++) begin
            w_gnt_oh[i] = (r_grant == 2'(i));
        end
    end

    // rready only ever follows the granted requester, and only while a burst is in DATA.
    assign bus.rready    = (r_state == S_DATA) && |(bus.m_rready & w_gnt_oh);
    assign w_beat        = bus.rvalid && bus.rready;
    assign w_err         = (bus.rid != r_arid) ||
                           (bus.rlast ? (r_beat_cnt != r_arlen) : (r_beat_cnt == r_arlen));

    assign bus.m_arready = (r_state == S_ADDR && bus.arready) ? w_gnt_oh : '0;
    assign bus.m_rvalid  = (r_state == S_DATA && bus.rvalid)  ? w_gnt_oh : '0;
    assign bus.m_rlast   = (r_state == S_DATA && bus.rlast)   ? w_gnt_oh : '0;
    assign bus.m_rdata   = bus.rdata;
    assign bus.m_rresp   = bus.rresp;

    assign bus.arid      = r_arid;
    assign bus.araddr    = r_araddr;
    assign bus.arlen     = r_arlen;
    assign bus.arsize    = 3'b010;
    assign bus.arburst   = 2'b01;
    assign bus.arlock    = 2'b00;
    assign bus.arcache   = 4'b0000;
    assign bus.arprot    = 3'b000;
    assign bus.arvalid   = r_arvalid;

    assign busy          = (r_state != S_IDLE);
    assign grant_id      = r_grant;
    assign proto_err     = r_proto_err;
    assign o_dbg_state   = r_state;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ADDR;
            S_ADDR:  if (bus.arready) w_next = S_DATA;
            S_DATA:  if (w_beat && bus.rlast) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A bad beat still completes the burst on rlast; the error just stays latched.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_arvalid   <= 1'b0;
            r_arid      <= 4'd0;
            r_araddr    <= 32'd0;
            r_arlen     <= 4'd0;
            r_grant     <= 2'd0;
            r_beat_cnt  <= 4'd0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_arvalid  <= 1'b1;
                        r_arid     <= w_arid;
                        r_araddr   <= w_addr;
                        r_arlen    <= w_len;
                        r_grant    <= w_winner;
                        r_beat_cnt <= 4'd0;
                    end
                end
                S_ADDR: begin
                    if (bus.arready) begin
                        r_arvalid <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                        if (w_err) begin
                            r_proto_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_sched.sv
// Randomized bench for axi_rd_sched: transaction-level arbitration model plus an R-beat scoreboard.
// Define ARB_RR_EN for both the design and this bench to exercise round-robin arbitration.
module tb_axi_rd_sched;

    localparam int NUM_M   = 2;
    localparam int ID_BASE = 0;

    logic        aclk;
    logic        aresetn;
    logic        busy;
    logic [1:0]  grant_id;
    logic        proto_err;
    logic [1:0]  dbg_state;

    axi_rd_sched_if #(.NUM_M(NUM_M)) bus ();

    axi_rd_sched #(
        .NUM_M   (NUM_M),
        .ID_BASE (ID_BASE)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .bus         (bus),
        .busy        (busy),
        .grant_id    (grant_id),
        .proto_err   (proto_err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping / model state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] req_addr [NUM_M];
    logic [3:0]  req_len  [NUM_M];
    int          mdl_ptr = 0;
    bit          mdl_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [NUM_M-1:0] onehot(input int g);
        logic [NUM_M-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // Arbitration rule: first requesting index at or after the priority pointer.
    task automatic model_pick(input logic [NUM_M-1:0] mask, output int g);
        int start;
`ifdef ARB_RR_EN
        start = mdl_ptr;
`else
        start = 0;
`endif
        g = -1;
        for (int k = 0; k < NUM_M; k++) begin
            if (g < 0 && mask[(start + k) % NUM_M]) g = (start + k) % NUM_M;
        end
        mdl_ptr = (g + 1) % NUM_M;
    endtask

    task automatic model_reset();
        mdl_ptr = 0;
        mdl_err = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        aresetn       = 1'b0;
        bus.m_arvalid = '0;
        bus.rvalid    = 1'b0;
        bus.rlast     = 1'b0;
        bus.arready   = 1'b0;
        step();
        aresetn = 1'b1;
        model_reset();
    endtask

    // bad_mode: 0 clean, 1 rlast on beat index 2, 2 rid differs from arid.
    task automatic run_burst(input logic [NUM_M-1:0] mask, input int ar_delay, input int bad_mode,
                             input int stall_len, input int abort_after, input bit hold_req);
        int          g;
        int          last_idx;
        int          n;
        int          cyc;
        int          stall_start;
        int          stalled;
        bit          in_stall;
        bit          beat;
        bit          last_now;
        bit          done;
        logic [3:0]  exp_id;
        logic [31:0] d;

        for (int i = 0; i < NUM_M; i++) begin
            bus.m_araddr[32*i +: 32] = req_addr[i];
            bus.m_arlen[4*i +: 4]    = req_len[i];
        end
        bus.m_arvalid = mask;
        bus.rvalid    = 1'b0;
        bus.rlast     = 1'b0;
        bus.arready   = 1'b0;
        model_pick(mask, g);
        exp_id = 4'(ID_BASE + g);
        #1;
        check("idle_m_arready", bus.m_arready, 0);
        check("idle_busy", busy, 0);
        step();
        if (!hold_req) bus.m_arvalid = '0;
        #1;
        check("req_arvalid", bus.arvalid, 1);
        check("req_arid", bus.arid, exp_id);
        check("req_araddr", bus.araddr, req_addr[g]);
        check("req_arlen", bus.arlen, req_len[g]);
        check("req_grant_id", grant_id, g);
        check("req_busy", busy, 1);

        for (int k = 0; k < ar_delay; k++) begin
            bus.arready = 1'b0;
            bus.rvalid  = 1'($urandom_range(0, 1));
            bus.rid     = exp_id;
            #1;
            check("addr_arvalid_hold", bus.arvalid, 1);
            check("addr_m_arready", bus.m_arready, 0);
            check("addr_rready", bus.rready, 0);
            check("addr_m_rvalid", bus.m_rvalid, 0);
            step();
        end
        bus.arready = 1'b1;
        bus.rvalid  = 1'b0;
        #1;
        check("addr_m_arready_steer", bus.m_arready, onehot(g));
        step();
        bus.arready = 1'b0;
        #1;
        check("data_arvalid_low", bus.arvalid, 0);

        last_idx    = (bad_mode == 1) ? 2 : int'(req_len[g]);
        stall_start = (stall_len > 0) ? int'($urandom_range(0, last_idx)) : -1;
        stalled     = 0;
        n           = 0;
        cyc         = 0;
        done        = 1'b0;
        while (!done && cyc < 300) begin
            in_stall       = (n == stall_start) && (stalled < stall_len);
            bus.rvalid     = in_stall ? 1'b1 : ($urandom_range(0, 3) != 0);
            d              = $urandom;
            bus.rdata      = d;
            bus.rresp      = 2'($urandom_range(0, 3));
            bus.rid        = (bad_mode == 2) ? (exp_id ^ 4'h1) : exp_id;
            bus.rlast      = bus.rvalid && (n == last_idx);
            bus.m_rready   = NUM_M'($urandom);
            bus.m_rready[g] = !in_stall;
            #1;
            check("data_busy", busy, 1);
            check("data_m_rvalid", bus.m_rvalid, bus.rvalid ? onehot(g) : '0);
            check("data_m_rlast", bus.m_rlast, bus.rlast ? onehot(g) : '0);
            check("data_rready", bus.rready, !in_stall);
            check("data_m_rresp", bus.m_rresp, bus.rresp);
            beat     = bus.rvalid && !in_stall;
            last_now = bus.rlast;
            if (beat) exp_q.push_back(d);
            if ((bus.m_rvalid & bus.m_rready & onehot(g)) != '0) begin
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else                   check("sb_rdata", bus.m_rdata, exp_q.pop_front());
            end
            if (in_stall) stalled++;
            step();
            cyc++;
            if (beat) begin
                n++;
                if (last_now) done = 1'b1;
            end
            if (abort_after > 0 && n == abort_after && !done) begin
                aresetn    = 1'b0;
                bus.rvalid = 1'b1;
                step();
                aresetn       = 1'b1;
                bus.m_arvalid = '0;
                #1;
                check("rst_arvalid", bus.arvalid, 0);
                check("rst_busy", busy, 0);
                check("rst_proto_err", proto_err, 0);
                check("rst_m_rvalid", bus.m_rvalid, 0);
                check("rst_rready", bus.rready, 0);
                bus.rvalid = 1'b0;
                model_reset();
                return;
            end
        end
        if (!done) check("data_timeout", 0, 1);
        if (bad_mode != 0) mdl_err = 1'b1;

        bus.rvalid = 1'b1;
        bus.rlast  = 1'b0;
        #1;
        check("end_busy", busy, 0);
        check("end_arvalid_gap", bus.arvalid, 0);
        check("end_rready_idle", bus.rready, 0);
        check("end_m_rvalid_idle", bus.m_rvalid, 0);
        check("end_beats", n, last_idx + 1);
        check("end_sb_empty", exp_q.size(), 0);
        check("end_proto_err", proto_err, mdl_err);
        bus.rvalid = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [NUM_M-1:0] mask;

        aresetn       = 1'b0;
        bus.m_araddr  = '0;
        bus.m_arlen   = '0;
        bus.m_arvalid = '0;
        bus.m_rready  = '0;
        bus.arready   = 1'b0;
        bus.rid       = 4'd0;
        bus.rdata     = 32'd0;
        bus.rresp     = 2'd0;
        bus.rlast     = 1'b0;
        bus.rvalid    = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            req_addr[i] = 32'd0;
            req_len[i]  = 4'd0;
        end
        repeat (3) step();
        bus.rvalid = 1'b1;
        #1;
        check("reset_arvalid", bus.arvalid, 0);
        check("reset_busy", busy, 0);
        check("reset_proto_err", proto_err, 0);
        check("reset_grant_id", grant_id, 0);
        check("reset_arid", bus.arid, 0);
        check("reset_araddr", bus.araddr, 0);
        check("reset_arlen", bus.arlen, 0);
        check("reset_m_rvalid", bus.m_rvalid, 0);
        check("reset_rready", bus.rready, 0);
        check("const_arsize", bus.arsize, 3'b010);
        check("const_arburst", bus.arburst, 2'b01);
        check("const_arlock", bus.arlock, 0);
        check("const_arcache", bus.arcache, 0);
        check("const_arprot", bus.arprot, 0);
        bus.rvalid = 1'b0;
        aresetn    = 1'b1;
        model_reset();
        step();

        // single refill from requester 1
        req_addr[0] = $urandom;
        req_addr[1] = 32'h1FC0_0000;
        req_len[1]  = 4'd7;
        run_burst(2'b10, 3, 0, 0, 0, 1'b0);

        // both requesting and held
        for (int k = 0; k < 4; k++) begin
            req_addr[0] = $urandom;
            req_addr[1] = $urandom;
            req_len[0]  = 4'($urandom_range(0, 4));
            req_len[1]  = 4'($urandom_range(0, 4));
            run_burst(2'b11, $urandom_range(0, 2), 0, 0, 0, 1'b1);
        end

        // backpressure mid-burst
        req_len[0] = 4'd7;
        run_burst(2'b01, 1, 0, 4, 0, 1'b0);

        // early rlast, then a clean burst with the error still latched
        req_len[0] = 4'd3;
        run_burst(2'b01, 0, 1, 0, 0, 1'b0);
        req_len[1] = 4'd2;
        run_burst(2'b10, 1, 0, 0, 0, 1'b0);

        // wrong rid from a fresh reset
        do_reset();
        req_len[1] = 4'd3;
        run_burst(2'b10, 1, 2, 0, 0, 1'b0);

        // reset in DATA after two beats (also clears the latched error)
        req_len[1] = 4'd7;
        run_burst(2'b10, 0, 0, 0, 2, 1'b0);
        step();

        // randomized traffic
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NUM_M; i++) begin
                req_addr[i] = $urandom;
                req_len[i]  = 4'($urandom_range(0, 15));
            end
            mask = NUM_M'($urandom_range(1, (1 << NUM_M) - 1));
            run_burst(mask, $urandom_range(0, 3), 0,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0,
                      0, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
